// File: rtl/bitblock_pkg.sv
// Shared types and constants for the bitblock_4 driver slice.
package bitblock_pkg;

    localparam int unsigned CELL_W = 5;
    localparam int unsigned CELLS  = 4;
    localparam int unsigned NIB_W  = 4;

    localparam logic MODE_4B = 1'b0;
    localparam logic MODE_8B = 1'b1;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRunLo = 3'd1,
        StRunHi = 3'd2,
        StFlush = 3'd3,
        StDone  = 3'd4
    } drv_state_e;

endpackage

// File: rtl/bitblock_4_drv.sv
// Sequences one bitblock_4_core through a 4-bit or 8-bit pass and returns the
// assembled partial sum over a valid/ready response.
module bitblock_4_drv
    import bitblock_pkg::*;
#(
    parameter int unsigned ACC_W = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [CELL_W*CELLS-1:0] req_in,
    input  logic [NIB_W-1:0]        req_yi,
    input  logic                    req_ci,
    input  logic                    req_mode,
    input  logic [ACC_W-1:0]        req_psum,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ACC_W-1:0]        rsp_data,
    output logic                    busy,
    output logic [CELL_W*CELLS-1:0] core_in,
    output logic [NIB_W-1:0]        core_yi,
    output logic                    core_shift,
    output logic                    core_shift_r1,
    output logic                    core_ppi,
    output logic                    core_ci,
    output logic [NIB_W-1:0]        core_psum,
    input  logic [NIB_W-1:0]        core_out,
    input  logic                    core_co
);

    drv_state_e                state_q, state_d;
    logic [CELL_W*CELLS-1:0]   in_q;
    logic [NIB_W-1:0]          yi_q;
    logic                      ci_q;
    logic                      mode_q;
    logic [ACC_W-1:0]          psum_q;
    logic [ACC_W-1:0]          result_q, result_d;
    logic                      shift_r1_q;
    logic                      load;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            in_q       <= '0;
            yi_q       <= '0;
            ci_q       <= 1'b0;
            mode_q     <= 1'b0;
            psum_q     <= '0;
            result_q   <= '0;
            shift_r1_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            shift_r1_q <= core_shift;
            if (load) begin
                in_q   <= req_in;
                yi_q   <= req_yi;
                ci_q   <= req_ci;
                mode_q <= req_mode;
                psum_q <= req_psum;
            end
        end
    end

    assign core_shift_r1 = shift_r1_q;
    assign busy          = (state_q != StIdle);

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        load       = 1'b0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_data   = '0;
        core_in    = '0;
        core_yi    = '0;
        core_shift = 1'b0;
        core_ppi   = 1'b0;
        core_ci    = 1'b0;
        core_psum  = '0;
        case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    load     = 1'b1;
                    result_d = '0;
                    state_d  = StRunLo;
                end
            end
            StRunLo: begin
                core_in       = in_q;
                core_yi       = yi_q;
                core_ci       = ci_q;
                core_psum     = psum_q[3:0];
                result_d[3:0] = core_out;
                state_d       = (mode_q == MODE_8B) ? StRunHi : StFlush;
            end
            StRunHi: begin
                core_in       = in_q;
                core_yi       = yi_q;
                core_shift    = 1'b1;
                core_psum     = psum_q[7:4];
                result_d[7:4] = core_out;
                state_d       = StFlush;
            end
            StFlush: begin
                // Core carry is registered, so it is only valid one cycle after the last pass.
                if (mode_q == MODE_8B) begin
                    result_d[8] = core_co;
                    for (int i = 9; i < ACC_W; i++) result_d[i] = psum_q[i];
                end else begin
                    result_d[4] = core_co;
                    for (int i = 5; i < ACC_W; i++) result_d[i] = psum_q[i];
                end
                state_d = StDone;
            end
            StDone: begin
                rsp_valid = 1'b1;
                rsp_data  = result_q;
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_bitblock_4_drv.sv
// Directed self-checking bench for bitblock_4_drv with a behavioural core stub.
module tb_bitblock_4_drv;

    localparam int unsigned ACC_W = 16;

    logic             clk = 1'b0;
    logic             rstn;
    logic             req_valid;
    logic             req_ready;
    logic [19:0]      req_in;
    logic [3:0]       req_yi;
    logic             req_ci;
    logic             req_mode;
    logic [ACC_W-1:0] req_psum;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [ACC_W-1:0] rsp_data;
    logic             busy;
    logic [19:0]      core_in;
    logic [3:0]       core_yi;
    logic             core_shift;
    logic             core_shift_r1;
    logic             core_ppi;
    logic             core_ci;
    logic [3:0]       core_psum;
    logic [3:0]       core_out;
    logic             core_co;

    logic [3:0] stub_lo, stub_hi;
    logic       stub_co;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Low nibble while unshifted, high nibble during the shifted pass.
    assign core_out = core_shift ? stub_hi : stub_lo;
    assign core_co  = stub_co;

    bitblock_4_drv #(.ACC_W(ACC_W)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_in        (req_in),
        .req_yi        (req_yi),
        .req_ci        (req_ci),
        .req_mode      (req_mode),
        .req_psum      (req_psum),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .busy          (busy),
        .core_in       (core_in),
        .core_yi       (core_yi),
        .core_shift    (core_shift),
        .core_shift_r1 (core_shift_r1),
        .core_ppi      (core_ppi),
        .core_ci       (core_ci),
        .core_psum     (core_psum),
        .core_out      (core_out),
        .core_co       (core_co)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_req_ready"}, req_ready, 1);
        check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
        check_eq({tag, "_rsp_data"}, rsp_data, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_core_in"}, core_in, 0);
        check_eq({tag, "_core_yi"}, core_yi, 0);
        check_eq({tag, "_core_shift"}, core_shift, 0);
        check_eq({tag, "_core_shift_r1"}, core_shift_r1, 0);
        check_eq({tag, "_core_ppi"}, core_ppi, 0);
        check_eq({tag, "_core_ci"}, core_ci, 0);
        check_eq({tag, "_core_psum"}, core_psum, 0);
    endtask

    task automatic do_req(input string tag, input logic mode, input logic [15:0] psum,
                          input logic [19:0] in, input logic [3:0] yi, input logic ci,
                          input logic [3:0] lo, input logic [3:0] hi, input logic co,
                          input logic [15:0] exp);
        int         n;
        logic [5:0] trace;
        stub_lo   = lo;
        stub_hi   = hi;
        stub_co   = co;
        req_mode  = mode;
        req_psum  = psum;
        req_in    = in;
        req_yi    = yi;
        req_ci    = ci;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        check_eq({tag, "_acc_ready"}, req_ready, 1);
        tick();
        req_valid = 1'b0;
        check_eq({tag, "_lo_in"}, core_in, in);
        check_eq({tag, "_lo_yi"}, core_yi, yi);
        check_eq({tag, "_lo_ci"}, core_ci, ci);
        check_eq({tag, "_lo_psum"}, core_psum, psum[3:0]);
        n     = 1;
        trace = '0;
        while (!rsp_valid && n < 20) begin
            trace = {trace[3:0], core_shift, core_shift_r1};
            tick();
            n++;
        end
        check_eq({tag, "_latency"}, n, mode ? 4 : 3);
        if (mode) check_eq({tag, "_shift_trace"}, trace, 6'b001001);
        check_eq({tag, "_data"}, rsp_data, exp);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq({tag, "_post_valid"}, rsp_valid, 0);
        check_eq({tag, "_post_data"}, rsp_data, 0);
    endtask

    initial begin
        int               n;
        logic [ACC_W-1:0] d1, d2;
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_in    = '0;
        req_yi    = '0;
        req_ci    = 1'b0;
        req_mode  = 1'b0;
        req_psum  = '0;
        rsp_ready = 1'b0;
        stub_lo   = '0;
        stub_hi   = '0;
        stub_co   = 1'b0;
        tick();
        tick();
        check_idle("rst_held");
        rstn = 1'b1;
        tick();
        check_idle("rst_idle");

        do_req("m0_a", 1'b0, 16'h1230, 20'hABCDE, 4'h7, 1'b1, 4'hA, 4'h0, 1'b1, 16'h123A);
        do_req("m0_b", 1'b0, 16'h1200, 20'h12345, 4'h3, 1'b0, 4'hA, 4'h0, 1'b1, 16'h121A);
        do_req("m0_c", 1'b0, 16'h0010, 20'h00001, 4'h1, 1'b0, 4'h3, 4'h0, 1'b0, 16'h0003);
        do_req("m1_a", 1'b1, 16'h0000, 20'h55555, 4'h9, 1'b1, 4'h5, 4'hC, 1'b1, 16'h01C5);
        do_req("m1_b", 1'b1, 16'hFF00, 20'hFEDCB, 4'hF, 1'b0, 4'h5, 4'hC, 1'b0, 16'hFEC5);

        // Backpressure: response held in DONE, a stray request is ignored.
        stub_lo = 4'h5; stub_hi = 4'hC; stub_co = 1'b1;
        req_mode = 1'b1; req_psum = 16'h0000; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq("bp_latency", n, 4);
        for (int i = 0; i < 10; i++) begin
            req_valid = (i == 4);
            req_psum  = 16'hFFFF;
            tick();
            check_eq("bp_data", rsp_data, 16'h01C5);
            check_eq("bp_req_ready", req_ready, 0);
        end
        req_valid = 1'b0;
        check_eq("bp_valid_held", rsp_valid, 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq("bp_release_busy", busy, 0);
        check_eq("bp_release_ready", req_ready, 1);

        // Reset during RUN_HI discards the operation.
        req_mode = 1'b1; req_psum = 16'h0000; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        check_eq("mid_hi_shift", core_shift, 1);
        rstn = 1'b0;
        tick();
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_valid", rsp_valid, 0);
        check_eq("mid_rst_shift", core_shift, 0);
        check_eq("mid_rst_shift_r1", core_shift_r1, 0);
        check_eq("mid_rst_ready", req_ready, 1);
        rstn = 1'b1;
        tick();
        do_req("after_rst", 1'b1, 16'h0000, 20'h0F0F0, 4'h2, 1'b1, 4'h5, 4'hC, 1'b1, 16'h01C5);

        // Back-to-back mode 0 requests with rsp_ready held high.
        stub_lo = 4'hA; stub_co = 1'b1;
        req_mode = 1'b0; req_psum = 16'h1230; req_valid = 1'b1; rsp_ready = 1'b1;
        d1 = '0;
        d2 = '0;
        tick();
        req_psum = 16'h1200;
        n = 1;
        while (!req_ready && n < 20) begin
            if (rsp_valid) d1 = rsp_data;
            tick();
            n++;
        end
        check_eq("b2b_gap", n, 4);
        check_eq("b2b_data1", d1, 16'h123A);
        tick();
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        d2 = rsp_data;
        check_eq("b2b_latency2", n, 3);
        check_eq("b2b_data2", d2, 16'h121A);
        tick();
        rsp_ready = 1'b0;
        check_eq("b2b_end_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/bitblock_4_drv.md
Name: bitblock_4_drv

Overview:
- Sequencer and collector that drives one bitblock_4_core instance from the MAC array side.
- Accepts a MAC request over a valid/ready handshake, applies the operand slice to the core, and sequences its shift, shift_r1, ppi, ci and psum controls for 4-bit or 8-bit precision.
- Captures the core's out nibbles and its registered carry, then returns the assembled partial sum over a valid/ready response.
- Sits between the array scheduler and each core column.

Parameters:
- ACC_W, 16, width of request psum and response data (must be at least 9).

Ports:
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_in  in  20  operand slices for the four cells, 5 bits each
- req_yi  in  4  weight nibble
- req_ci  in  1  carry-in for the low pass
- req_mode  in  1  0 = 4-bit (one pass), 1 = 8-bit (two passes)
- req_psum  in  ACC_W  incoming partial sum
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumed when rsp_valid & rsp_ready
- rsp_data  out  ACC_W  assembled result
- busy  out  1  high whenever state != IDLE
- core_in  out  20  to core in
- core_yi  out  4  to core yi
- core_shift  out  1  to core shift
- core_shift_r1  out  1  to core shift_r1
- core_ppi  out  1  to core ppi
- core_ci  out  1  to core ci
- core_psum  out  4  to core psum
- core_out  in  4  from core out (combinational)
- core_co  in  1  from core co (registered inside the core)

Behaviour:
- Reset (asynchronous, rstn low):
  - state = IDLE; all capture registers and result = 0.
  - core_shift_r1 = 0; rsp_valid = 0; req_ready = 1.
  - All core_* drive outputs = 0.
- core_shift_r1 is a flop of core_shift, reset 0. It is always exactly one cycle behind core_shift.
- FSM states: IDLE, RUN_LO, RUN_HI, FLUSH, DONE.
- IDLE:
  - req_ready = 1; all core_* outputs driven 0.
  - On handshake: capture in, yi, ci, mode and psum; clear result; go to RUN_LO.
- RUN_LO (1 cycle):
  - Drive core_in = in, core_yi = yi, core_ci = ci, core_ppi = 0, core_shift = 0, core_psum = psum[3:0].
  - At the clock edge: result[3:0] <= core_out.
  - Next state: RUN_HI if mode = 1, else FLUSH.
- RUN_HI (1 cycle):
  - Drive core_in and core_yi as in RUN_LO; core_ci = 0; core_ppi = 0; core_shift = 1; core_psum = psum[7:4].
  - At the clock edge: result[7:4] <= core_out.
  - Next state: FLUSH.
- FLUSH (1 cycle):
  - core_shift = 0; core_in, core_yi, core_ci, core_psum driven 0.
  - core_co now reflects the last pass.
  - Carry capture:
    - mode 0: result[4] <= core_co; result[ACC_W-1:5] <= psum[ACC_W-1:5].
    - mode 1: result[8] <= core_co; result[ACC_W-1:9] <= psum[ACC_W-1:9].
  - Next state: DONE.
- DONE:
  - rsp_valid = 1 and rsp_data = result, both held stable until rsp_ready.
  - On handshake: go to IDLE.
  - All core_* outputs driven 0.
- req_ready is high only in IDLE. No request is accepted in the same cycle a response completes; there is no back-to-back overlap.
- Latency from the accept edge to rsp_valid high: 3 cycles in mode 0, 4 cycles in mode 1. With rsp_ready held high, throughput is one request per 4 or 5 cycles.
- The shift pattern seen by the core (shift, shift_r1):
  - mode 1: (0,0) in RUN_LO, (1,0) in RUN_HI, (0,1) in FLUSH.
  - mode 0: stays (0,0).
- rsp_ready held low in DONE: remain in DONE indefinitely with data stable. req_valid is ignored during this time.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values. Any partial result is discarded and no response is issued.
- rsp_data is 0 whenever rsp_valid = 0.

Decomposition:
- Shared package bitblock_pkg holds:
  - state encoding (IDLE=0, RUN_LO=1, RUN_HI=2, FLUSH=3, DONE=4);
  - CELL_W=5, CELLS=4, NIB_W=4 constants;
  - MODE_4B=0 and MODE_8B=1.
- No sub-module is needed; the FSM, capture registers and the shift_r1 flop live in one module.

Test Plan:
- Reset then idle → req_ready=1, rsp_valid=0, busy=0, all core_* outputs = 0, core_shift_r1=0.
- mode 0, req_psum=16'h1230, core stub returns out=4'hA in RUN_LO and co=1 in FLUSH → rsp_valid 3 cycles after accept, rsp_data=16'h123A | (1<<4) = 16'h123A.
  - Note: bit 4 of that value is already psum[4]=1. Repeat with psum=16'h1200 → rsp_data=16'h121A.
- mode 1, psum=16'h0000, stub out=4'h5 then 4'hC, co=1 → rsp_data=16'h01C5 at 4 cycles. The (shift, shift_r1) trace must read (0,0), (1,0), (0,1).
- Backpressure: rsp_ready held low for 10 cycles in DONE → rsp_data is stable, req_ready=0, and a req_valid pulse is not accepted.
- Reset asserted during RUN_HI → next cycle: state IDLE, rsp_valid=0, core_shift=0, core_shift_r1=0. The following request completes normally.
- Two back-to-back mode 0 requests with rsp_ready=1 → second accepted exactly 4 cycles after the first; both results correct.
